// File: rtl/tx_scheduler_pkg.sv
// Shared TX slot definitions: header layout, default limits, fault codes and
// scheduler state encoding. The sender and host writer import the same package.
package tx_scheduler_pkg;

    localparam logic [15:0] DEF_MAGIC   = 16'h5555;
    localparam logic [15:0] DEF_MIN_LEN = 16'd60;
    localparam logic [15:0] DEF_MAX_LEN = 16'd1518;

    localparam int HDR_MAGIC   = 0;
    localparam int HDR_LEN     = 1;
    localparam int HDR_TS      = 2;
    localparam int HDR_TS_LAST = 5;
    localparam int HDR_HASH    = 6;
    localparam int HDR_WORDS   = 8;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WAIT,
        ST_RELEASE,
        ST_HALT
    } sched_state_t;

    // Header plus payload rounded up to whole 16-bit words, mod 2^14.
    function automatic logic [13:0] frame_words(input logic [15:0] frame_len);
        return 14'(HDR_WORDS) + 14'(({1'b0, frame_len} + 17'd1) >> 1);
    endfunction

endpackage

// File: rtl/tx_scheduler.sv
// Releases whole TX frames to the GMII sender once their timestamp is due,
// parsing each slot header through a second read port of the slot memory.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter logic [15:0] MAGIC   = DEF_MAGIC,
    parameter logic [15:0] MIN_LEN = DEF_MIN_LEN,
    parameter logic [15:0] MAX_LEN = DEF_MAX_LEN
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst,
    input  logic [63:0] global_counter,
    input  logic        sched_en,
    input  logic [13:0] host_wr_ptr,
    output logic [13:0] sched_rd_addr,
    input  logic [15:0] sched_rd_q,
    output logic [13:0] sched_wr_ptr,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] late_cnt,
    output logic [31:0] sent_cnt
);

    sched_state_t state_reg;
    logic [2:0]   hdr_idx_reg;
    logic [13:0]  scan_ptr_reg;
    logic [13:0]  rd_addr_reg;
    logic [13:0]  wr_ptr_reg;
    logic [15:0]  len_reg;
    logic [63:0]  ts_reg;
    logic         late_reg;
    logic         err_reg;
    logic [1:0]   err_code_reg;
    logic [15:0]  late_cnt_reg;
    logic [31:0]  sent_cnt_reg;

    logic [13:0]  avail;
    logic [13:0]  fwords;
    logic         ts_due;
    logic         release_ok;

    assign avail      = host_wr_ptr - scan_ptr_reg;
    assign fwords     = frame_words(len_reg);
    assign ts_due     = (ts_reg == 64'd0) || (global_counter >= ts_reg);
    assign release_ok = sched_en && (avail >= fwords) && ts_due;

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state_reg    <= ST_IDLE;
            hdr_idx_reg  <= 3'd0;
            scan_ptr_reg <= 14'd0;
            rd_addr_reg  <= 14'd0;
            wr_ptr_reg   <= 14'd0;
            len_reg      <= 16'd0;
            ts_reg       <= 64'd0;
            late_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
            late_cnt_reg <= 16'd0;
            sent_cnt_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (avail >= 14'(HDR_WORDS)) begin
                        rd_addr_reg <= scan_ptr_reg;
                        hdr_idx_reg <= 3'd0;
                        state_reg   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    // Word k arrives on sched_rd_q while hdr_idx == k + 1.
                    hdr_idx_reg <= hdr_idx_reg + 3'd1;
                    if (hdr_idx_reg < 3'(HDR_TS_LAST))
                        rd_addr_reg <= scan_ptr_reg + 14'(hdr_idx_reg) + 14'd1;
                    case (hdr_idx_reg)
                        3'(HDR_MAGIC + 1): begin
                            if (sched_rd_q != MAGIC) begin
                                err_reg      <= 1'b1;
                                err_code_reg <= ERR_MAGIC;
                                state_reg    <= ST_HALT;
                            end
                        end
                        3'(HDR_LEN + 1): begin
                            len_reg <= sched_rd_q;
                            if (sched_rd_q < MIN_LEN || sched_rd_q > MAX_LEN) begin
                                err_reg      <= 1'b1;
                                err_code_reg <= ERR_LEN;
                                state_reg    <= ST_HALT;
                            end
                        end
                        3'(HDR_TS + 1), 3'(HDR_TS + 2), 3'(HDR_TS + 3): begin
                            ts_reg <= {ts_reg[47:0], sched_rd_q};
                        end
                        3'(HDR_TS_LAST + 1): begin
                            ts_reg    <= {ts_reg[47:0], sched_rd_q};
                            state_reg <= ST_WAIT;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT: begin
                    if (release_ok) begin
                        late_reg  <= (ts_reg != 64'd0) && (global_counter > ts_reg);
                        state_reg <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    wr_ptr_reg   <= scan_ptr_reg + fwords;
                    scan_ptr_reg <= scan_ptr_reg + fwords;
                    sent_cnt_reg <= sent_cnt_reg + 32'd1;
                    if (late_reg && late_cnt_reg != 16'hFFFF)
                        late_cnt_reg <= late_cnt_reg + 16'd1;
                    state_reg <= ST_IDLE;
                end
                ST_HALT: ;
                default: state_reg <= ST_HALT;
            endcase
        end
    end

    assign sched_rd_addr = rd_addr_reg;
    assign sched_wr_ptr  = wr_ptr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign err           = err_reg;
    assign err_code      = err_code_reg;
    assign late_cnt      = late_cnt_reg;
    assign sent_cnt      = sent_cnt_reg;

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: slot memory model, single-frame vector table,
// hand-written timing corners and a randomized multi-frame scoreboard.
module tb_tx_scheduler;

    logic        clk;
    logic        sys_rst;
    logic [63:0] gc;
    logic        sched_en;
    logic [13:0] host_wr_ptr;
    logic [13:0] sched_rd_addr;
    logic [15:0] sched_rd_q;
    logic [13:0] sched_wr_ptr;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] late_cnt;
    logic [31:0] sent_cnt;

    logic [15:0] mem [0:16383];

    int n_pass  = 0;
    int n_total = 0;

    tx_scheduler dut (
        .gmii_tx_clk    (clk),
        .sys_rst        (sys_rst),
        .global_counter (gc),
        .sched_en       (sched_en),
        .host_wr_ptr    (host_wr_ptr),
        .sched_rd_addr  (sched_rd_addr),
        .sched_rd_q     (sched_rd_q),
        .sched_wr_ptr   (sched_wr_ptr),
        .busy           (busy),
        .err            (err),
        .err_code       (err_code),
        .late_cnt       (late_cnt),
        .sent_cnt       (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) sched_rd_q <= mem[sched_rd_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; afterwards the outputs and gc both describe the upcoming cycle.
    task automatic step();
        @(posedge clk);
        #1;
        gc = gc + 64'd1;
    endtask

    task automatic do_reset();
        sys_rst     = 1'b1;
        sched_en    = 1'b1;
        host_wr_ptr = 14'd0;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    task automatic write_frame(input logic [13:0] base, input logic [15:0] magic,
                               input logic [15:0] len, input logic [63:0] ts);
        logic [15:0] w [6];
        logic [13:0] a;
        w[0] = magic;
        w[1] = len;
        w[2] = ts[63:48];
        w[3] = ts[47:32];
        w[4] = ts[31:16];
        w[5] = ts[15:0];
        a = base;
        for (int i = 0; i < 6; i++) begin
            mem[a] = w[i];
            a = a + 14'd1;
        end
    endtask

    typedef struct {
        logic [15:0] magic;
        logic [15:0] len;
        logic [63:0] ts;
        logic [63:0] gc0;
        logic [13:0] host;
        logic [13:0] exp_ptr;
        logic [15:0] exp_late;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[8];

    logic [13:0] exp_q [$];
    logic [63:0] ts_q  [$];
    bit          fut_q [$];

    initial begin
        int          steps;
        logic        timed_out;
        logic [5:0]  seen;
        logic [13:0] base;
        logic [13:0] last_ptr;
        logic [15:0] len;
        logic [63:0] ts;
        logic [63:0] exp_ts;
        logic [15:0] late_exp;
        logic [13:0] words;
        int          mode;
        bit          fut;

        for (int i = 0; i < 16384; i++) mem[i] = 16'(i);
        gc          = 64'd0;
        sys_rst     = 1'b1;
        sched_en    = 1'b1;
        host_wr_ptr = 14'd0;

        // ---- reset state ----
        do_reset();
        check("rst_rd_addr", sched_rd_addr, 0);
        check("rst_wr_ptr", sched_wr_ptr, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_late_cnt", late_cnt, 0);
        check("rst_sent_cnt", sent_cnt, 0);

        // ---- single-frame vector table ----
        vecs[0] = '{16'h5555, 16'd60,   64'd0,  64'd5,   14'd38,  14'd38,  16'd0, 1'b0, 2'd0};
        vecs[1] = '{16'h5555, 16'd60,   64'd50, 64'd800, 14'd38,  14'd38,  16'd1, 1'b0, 2'd0};
        vecs[2] = '{16'h5555, 16'd1518, 64'd0,  64'd5,   14'd767, 14'd767, 16'd0, 1'b0, 2'd0};
        vecs[3] = '{16'h5555, 16'd61,   64'd0,  64'd5,   14'd39,  14'd39,  16'd0, 1'b0, 2'd0};
        vecs[4] = '{16'h1234, 16'd60,   64'd0,  64'd5,   14'd38,  14'd0,   16'd0, 1'b1, 2'd1};
        vecs[5] = '{16'h5555, 16'd2000, 64'd0,  64'd5,   14'd38,  14'd0,   16'd0, 1'b1, 2'd2};
        vecs[6] = '{16'h5555, 16'd59,   64'd0,  64'd5,   14'd38,  14'd0,   16'd0, 1'b1, 2'd2};
        vecs[7] = '{16'h5555, 16'd1519, 64'd0,  64'd5,   14'd38,  14'd0,   16'd0, 1'b1, 2'd2};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            gc = vecs[v].gc0;
            write_frame(14'd0, vecs[v].magic, vecs[v].len, vecs[v].ts);
            host_wr_ptr = vecs[v].host;
            steps = 0;
            timed_out = 1'b1;
            for (int c = 0; c < 40; c++) begin
                step();
                steps++;
                if (sched_wr_ptr != 14'd0 || err) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            check($sformatf("vec%0d_timeout", v), timed_out, 0);
            check($sformatf("vec%0d_wr_ptr", v), sched_wr_ptr, vecs[v].exp_ptr);
            check($sformatf("vec%0d_sent", v), sent_cnt, vecs[v].exp_err ? 0 : 1);
            check($sformatf("vec%0d_late", v), late_cnt, vecs[v].exp_late);
            check($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
            check($sformatf("vec%0d_err_code", v), err_code, vecs[v].exp_code);
            if (!vecs[v].exp_err) begin
                check($sformatf("vec%0d_latency_le10", v), (steps <= 10), 1);
            end else begin
                host_wr_ptr = host_wr_ptr + 14'd100;
                repeat (20) step();
                check($sformatf("vec%0d_halt_wr_ptr", v), sched_wr_ptr, 0);
                check($sformatf("vec%0d_halt_busy", v), busy, 1);
                check($sformatf("vec%0d_halt_err", v), err, 1);
            end
        end

        // ---- timed release: pointer moves exactly when gc reaches ts + 2 ----
        do_reset();
        gc = 64'd900;
        write_frame(14'd0, 16'h5555, 16'd60, 64'd1000);
        host_wr_ptr = 14'd38;
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step();
            if (sched_wr_ptr != 14'd0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("timed_timeout", timed_out, 0);
        check("timed_gc_at_release", gc, 64'd1002);
        check("timed_wr_ptr", sched_wr_ptr, 38);
        check("timed_late", late_cnt, 0);

        // ---- sched_en gating ----
        do_reset();
        gc = 64'd100;
        sched_en = 1'b0;
        write_frame(14'd0, 16'h5555, 16'd60, 64'd0);
        host_wr_ptr = 14'd38;
        repeat (30) step();
        check("gate_hold_wr_ptr", sched_wr_ptr, 0);
        check("gate_hold_busy", busy, 1);
        sched_en = 1'b1;
        step();
        check("gate_plus1_wr_ptr", sched_wr_ptr, 0);
        step();
        check("gate_plus2_wr_ptr", sched_wr_ptr, 38);

        // ---- partial write held in WAIT ----
        do_reset();
        write_frame(14'd0, 16'h5555, 16'd60, 64'd0);
        host_wr_ptr = 14'd20;
        repeat (30) step();
        check("partial_hold_wr_ptr", sched_wr_ptr, 0);
        check("partial_hold_busy", busy, 1);
        host_wr_ptr = 14'd38;
        step();
        check("partial_plus1_wr_ptr", sched_wr_ptr, 0);
        step();
        check("partial_plus2_wr_ptr", sched_wr_ptr, 38);

        // ---- walk the scan pointer to 0x3FF0 with 22 frames of 744 words ----
        do_reset();
        gc = 64'd10;
        base = 14'd0;
        for (int i = 0; i < 22; i++) begin
            write_frame(base, 16'h5555, 16'd1472, 64'd0);
            base = base + 14'd744;
        end
        host_wr_ptr = 14'h3FF0;
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (sched_wr_ptr == 14'h3FF0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("fill_timeout", timed_out, 0);
        check("fill_sent", sent_cnt, 22);

        // ---- frame straddling the 0x3FFF -> 0x0000 boundary ----
        write_frame(14'h3FF0, 16'h5555, 16'd61, 64'd0);
        host_wr_ptr = 14'h0017;
        seen = 6'd0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (sched_rd_addr >= 14'h3FF0 && sched_rd_addr <= 14'h3FF5)
                seen[sched_rd_addr - 14'h3FF0] = 1'b1;
        end
        check("wrap_wr_ptr", sched_wr_ptr, 14'h0017);
        check("wrap_rd_addrs_seen", seen, 6'h3F);
        check("wrap_sent", sent_cnt, 23);

        // ---- randomized multi-frame scoreboard ----
        gc = {32'h0000_0001, $urandom};
        base = 14'h0017;
        late_exp = 16'd0;
        for (int i = 0; i < 12; i++) begin
            len  = 16'($urandom_range(60, 1518));
            mode = $urandom_range(0, 2);
            fut  = 1'b0;
            if (mode == 0) begin
                ts = 64'd0;
            end else if (mode == 1) begin
                ts = gc - 64'd1 - 64'($urandom_range(0, 100000));
                late_exp = late_exp + 16'd1;
            end else begin
                ts = gc + 64'(150 * (i + 1));
                fut = 1'b1;
            end
            write_frame(base, 16'h5555, len, ts);
            words = 14'(8 + (int'(len) + 1) / 2);
            base = base + words;
            exp_q.push_back(base);
            ts_q.push_back(ts);
            fut_q.push_back(fut);
        end
        last_ptr = sched_wr_ptr;
        host_wr_ptr = base;
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (sched_wr_ptr != last_ptr) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_release", sched_wr_ptr, last_ptr);
                end else begin
                    exp_ts = ts_q.pop_front();
                    check("rand_release_ptr", sched_wr_ptr, exp_q.pop_front());
                    if (fut_q.pop_front())
                        check("rand_release_time", gc, exp_ts + 64'd2);
                end
                last_ptr = sched_wr_ptr;
            end
            if (exp_q.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("rand_timeout", timed_out, 0);
        repeat (3) step();
        check("rand_final_wr_ptr", sched_wr_ptr, base);
        check("rand_sent", sent_cnt, 35);
        check("rand_late", late_cnt, late_exp);
        check("rand_err", err, 0);
        check("rand_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Sits between the host-side TX slot writer and the GMII sender, in the gmii_tx_clk domain.
- Walks the TX slot memory through a second read port and parses each frame header (magic, length, 64-bit timestamp).
- Advances the write pointer seen by the sender one whole frame at a time, only once global_counter reaches the frame's timestamp.
- Timestamp 0 means send as soon as possible. Header corruption is detected and the block halts.

Parameters:
- MAGIC, 16'h5555, required value of header word 0.
- MIN_LEN, 16'd60, minimum legal frame_len in bytes.
- MAX_LEN, 16'd1518, maximum legal frame_len in bytes.

Ports:
- gmii_tx_clk  in  1  clock.
- sys_rst  in  1  synchronous, active-high reset.
- global_counter  in  64  free-running time base, same counter the sender sees.
- sched_en  in  1  1 = releases allowed.
- host_wr_ptr  in  14  word pointer one past the last completely written frame.
- sched_rd_addr  out  14  slot memory read address; data returns one cycle later.
- sched_rd_q  in  16  slot memory read data.
- sched_wr_ptr  out  14  drives the sender's mem_wr_ptr.
- busy  out  1  state is not IDLE.
- err  out  1  sticky fault flag.
- err_code  out  2  fault cause: 1 = bad magic, 2 = bad length.
- late_cnt  out  16  frames released after their timestamp had already passed; saturating.
- sent_cnt  out  32  frames released; wraps.

Behaviour:
- Reset values:
  - All outputs 0.
  - scan_ptr = 0.
  - State = IDLE.
  - Reset mid-frame abandons the frame; the host writer and sender are reset by the same sys_rst.
- Slot frame layout, in 16-bit words from the frame base:
  - w0 magic.
  - w1 frame_len (bytes).
  - w2..w5 timestamp, MSW first.
  - w6..w7 hash, ignored here.
  - then data words.
- frame_words = 8 + ((frame_len + 1) >> 1), computed in 14 bits.
- All pointer arithmetic is mod 2^14. avail = host_wr_ptr - scan_ptr (mod 2^14).
- sched_rd_addr = scan_ptr + hdr_idx. The address is registered; each data word is captured one cycle after its address.
- IDLE:
  - If avail >= 8, go to HDR with hdr_idx = 0.
  - avail = 0 means empty.
- HDR:
  - Issues addresses for w0..w5, one per cycle, and captures the data a cycle later.
  - Takes 7 cycles from the first address to the w5 capture.
  - After capture of w0: if w0 != MAGIC, set err = 1 and err_code = 1, go to HALT.
  - After capture of w1: if frame_len < MIN_LEN or frame_len > MAX_LEN, set err = 1 and err_code = 2, go to HALT.
  - After w5 is captured, go to WAIT.
- WAIT:
  - Release condition: sched_en = 1, AND avail >= frame_words, AND (timestamp == 0 OR global_counter >= timestamp).
  - global_counter >= timestamp is an unsigned 64-bit compare.
  - When the condition holds, go to RELEASE.
  - Record late = (timestamp != 0 AND global_counter > timestamp) at that same cycle.
- RELEASE (one cycle):
  - sched_wr_ptr <= scan_ptr + frame_words.
  - scan_ptr <= the same value.
  - sent_cnt += 1.
  - If late, late_cnt += 1, saturating at 16'hFFFF.
  - Go to IDLE.
- Latency:
  - sched_wr_ptr updates 2 cycles after the cycle in which global_counter == timestamp is first seen in WAIT: one cycle to RELEASE, then the register update.
  - Minimum frame-to-frame scheduling overhead is 10 cycles: IDLE 1, HDR 7, WAIT 1, RELEASE 1.
- sched_wr_ptr never moves backwards and moves only in whole-frame steps, so the sender never starts a partial frame.
- Pointer wrap-around is handled purely by mod-2^14 arithmetic. A frame may straddle the 0x3FFF→0x0000 boundary.
- sched_en = 0 holds the block in WAIT. IDLE and HDR still proceed.
- HALT:
  - Terminal until sys_rst.
  - sched_wr_ptr is frozen; the sender drains frames already released.
  - err remains 1 in HALT.
- host_wr_ptr changing in the same cycle as a WAIT evaluation: the registered value from that cycle is used; no glitch tolerance is required.
- Free-space flow control toward the host is outside this block. The host compares its pointer against the sender's mem_rd_ptr.

Decomposition:
- Shared include tx_slot_defs.vh contains:
  - Header word offsets: HDR_MAGIC = 0, HDR_LEN = 1, HDR_TS = 2..5, HDR_HASH = 6..7, HDR_WORDS = 8.
  - MAGIC default.
  - err_code encodings.
  - State encoding: IDLE, HDR, WAIT, RELEASE, HALT.
- The sender and the host writer use the same include.
- No sub-module; header capture, compare and pointer update fit in one FSM.

Test Plan:
- Immediate release: one frame, ts = 0, len = 60 (38 words) at base 0, host_wr_ptr = 38 → sched_wr_ptr = 38 within 10 cycles; sent_cnt = 1; late_cnt = 0.
- Timed release: ts = 1000, global_counter starting at 900 → sched_wr_ptr stays 0 until the counter reaches 1000, then becomes 38 exactly 2 cycles later.
- Late frame: ts = 50 while global_counter = 800 → released immediately; late_cnt = 1.
- Wrap-around: base 0x3FF0, len = 61 (39 words), host_wr_ptr = 0x0017 → sched_wr_ptr = 0x0017; sched_rd_addr visits 0x3FF0..0x3FF5.
- Faults:
  - w0 = 16'h1234 → err = 1, err_code = 1, HALT; sched_wr_ptr unchanged; host_wr_ptr advance ignored.
  - Repeat with len = 2000 → err_code = 2.
- Gating and partial writes:
  - sched_en = 0 with a due frame → no release; raising sched_en releases it 2 cycles later.
  - host_wr_ptr = base + 20 for a 38-word frame → header parsed, held in WAIT until host_wr_ptr = base + 38.
